// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command frame parser.
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_DHI,
        ST_DLO,
        ST_CSUM
    } parser_state_t;

    localparam logic [7:0] HEADER_DEFAULT   = 8'hA5;
    localparam int         FRAME_LEN_CSUM   = 5;
    localparam int         FRAME_LEN_NOCSUM = 4;

    // 8-bit wrapping sum of the three frame body bytes.
    function automatic logic [7:0] frame_csum(input logic [7:0] c,
                                              input logic [7:0] dhi,
                                              input logic [7:0] dlo);
        return c + dhi + dlo;
    endfunction

endpackage

// File: rtl/uart_cmd_parser_if.sv
// Byte-in / command-out bundle between a UART receiver and the command parser.
interface uart_cmd_parser_if;

    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  cmd;
    logic [15:0] cmd_data;
    logic        cmd_valid;
    logic        frame_err;
    logic        busy;

    modport master (
        output rx_data, rx_valid,
        input  cmd, cmd_data, cmd_valid, frame_err, busy
    );

    modport slave (
        input  rx_data, rx_valid,
        output cmd, cmd_data, cmd_valid, frame_err, busy
    );

endinterface

// File: rtl/uart_cmd_timeout.sv
// Inter-byte timeout: 24-bit up-counter, expire flags the last count while enabled.
module uart_cmd_timeout #(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic RST_clk,
    input  logic RST_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [23:0] CNT_LAST = 24'(TIMEOUT_CYC - 1);

    logic [23:0] cnt;

    always_ff @(posedge RST_clk or negedge RST_n) begin
        if (!RST_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + 24'd1;
        end
    end

    assign expire = enable && (cnt == CNT_LAST);

endmodule

// File: rtl/uart_cmd_parser.sv
// Parses HEADER,CMD,DHI,DLO[,CSUM] byte frames; UART_CMD_CHECKSUM_EN adds the CSUM byte check.
//   state   | meaning
//   IDLE    | hunting for HEADER, other bytes dropped
//   CMD     | next byte is the command code
//   DHI     | next byte is payload high
//   DLO     | next byte is payload low
//   CSUM    | next byte is the checksum (checksum build only)
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0] HEADER      = HEADER_DEFAULT,
    parameter int         TIMEOUT_CYC = 50000
) (
    input  logic               RST_clk,
    input  logic               RST_n,
    uart_cmd_parser_if.slave   bus
);

    parser_state_t state;
    logic [7:0]    cmd_b;
    logic [7:0]    dhi_b;
`ifdef UART_CMD_CHECKSUM_EN
    logic [7:0]    dlo_b;
`endif
    logic [7:0]    cmd_q;
    logic [15:0]   data_q;
    logic          valid_q;
    logic          err_q;

    logic tmo_clear;
    logic tmo_enable;
    logic tmo_expire;

    // Clearing on expire too means the counter is already zero when IDLE is re-entered.
    assign tmo_enable = (state != ST_IDLE);
    assign tmo_clear  = bus.rx_valid || (state == ST_IDLE) || tmo_expire;

    uart_cmd_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .RST_clk (RST_clk),
        .RST_n   (RST_n),
        .clear   (tmo_clear),
        .enable  (tmo_enable),
        .expire  (tmo_expire)
    );

    always_ff @(posedge RST_clk or negedge RST_n) begin
        if (!RST_n) begin
            state   <= ST_IDLE;
            cmd_b   <= '0;
            dhi_b   <= '0;
`ifdef UART_CMD_CHECKSUM_EN
            dlo_b   <= '0;
`endif
            cmd_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            // A byte arriving on the expiry cycle takes priority over the timeout.
            if (bus.rx_valid) begin
                case (state)
                    ST_IDLE: begin
                        if (bus.rx_data == HEADER) begin
                            state <= ST_CMD;
                        end
                    end
                    ST_CMD: begin
                        cmd_b <= bus.rx_data;
                        state <= ST_DHI;
                    end
                    ST_DHI: begin
                        dhi_b <= bus.rx_data;
                        state <= ST_DLO;
                    end
`ifdef UART_CMD_CHECKSUM_EN
                    ST_DLO: begin
                        dlo_b <= bus.rx_data;
                        state <= ST_CSUM;
                    end
                    ST_CSUM: begin
                        if (bus.rx_data == frame_csum(cmd_b, dhi_b, dlo_b)) begin
                            cmd_q   <= cmd_b;
                            data_q  <= {dhi_b, dlo_b};
                            valid_q <= 1'b1;
                        end else begin
                            err_q   <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end
`else
                    ST_DLO: begin
                        cmd_q   <= cmd_b;
                        data_q  <= {dhi_b, bus.rx_data};
                        valid_q <= 1'b1;
                        state   <= ST_IDLE;
                    end
`endif
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end else if (tmo_expire) begin
                err_q <= 1'b1;
                state <= ST_IDLE;
            end
        end
    end

    assign bus.cmd       = cmd_q;
    assign bus.cmd_data  = data_q;
    assign bus.cmd_valid = valid_q;
    assign bus.frame_err = err_q;
    assign bus.busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser; follows UART_CMD_CHECKSUM_EN like the design.
module tb_uart_cmd_parser;

    localparam int         TO   = 40;
    localparam logic [7:0] HDR  = 8'hA5;
`ifdef UART_CMD_CHECKSUM_EN
    localparam bit         CSUM_ON = 1'b1;
    localparam int         FLEN    = 5;
`else
    localparam bit         CSUM_ON = 1'b0;
    localparam int         FLEN    = 4;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    uart_cmd_parser_if bus();

    uart_cmd_parser #(
        .HEADER      (HDR),
        .TIMEOUT_CYC (TO)
    ) dut (
        .RST_clk (clk),
        .RST_n   (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    wire [26:0] obs = {bus.cmd_valid, bus.frame_err, bus.busy, bus.cmd, bus.cmd_data};

    // Reference model: a byte queue holding the partial frame plus an idle-gap count.
    logic [7:0]  mbuf[$];
    int          gap;
    logic [7:0]  m_cmd;
    logic [15:0] m_data;
    logic [26:0] expv;

    logic [8:0]  stimq[$];

    task automatic model_reset();
        mbuf.delete();
        gap    = 0;
        m_cmd  = '0;
        m_data = '0;
        expv   = '0;
    endtask

    task automatic model_step(input logic v, input logic [7:0] d);
        logic m_valid;
        logic m_err;
        m_valid = 1'b0;
        m_err   = 1'b0;
        if (mbuf.size() == 0) begin
            if (v && d == HDR) begin
                mbuf.push_back(d);
                gap = 0;
            end
        end else if (v) begin
            mbuf.push_back(d);
            gap = 0;
            if (mbuf.size() == FLEN) begin
                if (!CSUM_ON || mbuf[FLEN-1] == 8'(mbuf[1] + mbuf[2] + mbuf[3])) begin
                    m_valid = 1'b1;
                    m_cmd   = mbuf[1];
                    m_data  = {mbuf[2], mbuf[3]};
                end else begin
                    m_err = 1'b1;
                end
                mbuf.delete();
            end
        end else begin
            gap++;
            if (gap >= TO) begin
                m_err = 1'b1;
                mbuf.delete();
            end
        end
        expv = {m_valid, m_err, (mbuf.size() != 0), m_cmd, m_data};
    endtask

    task automatic drive(input logic [8:0] s);
        bus.rx_valid = s[8];
        bus.rx_data  = s[7:0];
        model_step(s[8], s[7:0]);
        @(posedge clk);
        #1;
    endtask

    task automatic add_byte(input logic [7:0] b);
        stimq.push_back({1'b1, b});
    endtask

    task automatic add_idle(input int n);
        for (int i = 0; i < n; i++) stimq.push_back({1'b0, 8'($urandom)});
    endtask

    task automatic add_frame(input logic [7:0] c, input logic [15:0] dat,
                             input bit good, input int gapmax);
        logic [7:0] cs;
        cs = 8'(c + dat[15:8] + dat[7:0]);
        if (!good) cs = cs ^ 8'h01;
        add_byte(HDR);       add_idle($urandom_range(0, gapmax));
        add_byte(c);         add_idle($urandom_range(0, gapmax));
        add_byte(dat[15:8]); add_idle($urandom_range(0, gapmax));
        add_byte(dat[7:0]);
        if (CSUM_ON) begin
            add_idle($urandom_range(0, gapmax));
            add_byte(cs);
        end
    endtask

    task automatic test_reset();
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (obs !== 27'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp %h", obs, 27'd0);
        end
        bus.rx_valid = 1'b1;
        bus.rx_data  = HDR;
        @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ignores_bytes busy got %b exp 0", bus.busy);
        end
        bus.rx_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [7:0]  want_cmd [3];
        logic [15:0] want_data[3];
        int nv = 0;
        int ne = 0;
`ifdef UART_CMD_CHECKSUM_EN
        want_cmd  = '{8'h01, 8'h01, 8'h02};
        want_data = '{16'h1234, 16'h1234, 16'hA500};
`else
        want_cmd  = '{8'h03, 8'h03, 8'h02};
        want_data = '{16'h00FF, 16'h00FF, 16'hA500};
`endif
        for (int p = 0; p < 3; p++) begin
            stimq.delete();
`ifdef UART_CMD_CHECKSUM_EN
            case (p)
                0: begin add_byte(8'hA5); add_byte(8'h01); add_byte(8'h12); add_byte(8'h34); add_byte(8'h47); end
                1: begin add_byte(8'hA5); add_byte(8'h01); add_byte(8'h12); add_byte(8'h34); add_byte(8'h48); end
                default: begin
                    add_byte(8'h00); add_byte(8'hFF); add_byte(8'hA5); add_byte(8'h02);
                    add_byte(8'hA5); add_byte(8'h00); add_byte(8'hA7);
                end
            endcase
`else
            case (p)
                0: begin add_byte(8'hA5); add_byte(8'h03); add_byte(8'h00); add_byte(8'hFF); end
                1: begin add_byte(8'h00); add_byte(8'hFF); end
                default: begin add_byte(8'hA5); add_byte(8'h02); add_byte(8'hA5); add_byte(8'h00); end
            endcase
`endif
            foreach (stimq[i]) begin
                drive(stimq[i]);
                nv += int'(bus.cmd_valid);
                ne += int'(bus.frame_err);
                checks++;
                if (obs !== expv) begin
                    errors++;
                    $display("FAIL directed_stream p=%0d i=%0d got %h exp %h", p, i, obs, expv);
                end
            end
            checks++;
            if (bus.cmd !== want_cmd[p] || bus.cmd_data !== want_data[p]) begin
                errors++;
                $display("FAIL directed_result p=%0d got %h/%h exp %h/%h",
                         p, bus.cmd, bus.cmd_data, want_cmd[p], want_data[p]);
            end
        end
        checks++;
        if (nv !== 2 || ne !== (CSUM_ON ? 1 : 0)) begin
            errors++;
            $display("FAIL directed_pulses got valid=%0d err=%0d exp valid=2 err=%0d",
                     nv, ne, CSUM_ON ? 1 : 0);
        end
    endtask

    task automatic test_timeout();
        int nv = 0;
        int ne = 0;
        stimq.delete();
        add_byte(HDR); add_byte(8'h01); add_idle(TO);
        add_frame(8'h11, 16'h2233, 1'b1, 0);
        // byte arrives on the very cycle the counter is at its last value
        add_byte(HDR); add_idle(TO - 1);
        add_byte(8'h01); add_byte(8'h00); add_byte(8'h10);
        if (CSUM_ON) add_byte(8'h11);
        add_byte(HDR); add_idle(TO + 3);
        foreach (stimq[i]) begin
            drive(stimq[i]);
            nv += int'(bus.cmd_valid);
            ne += int'(bus.frame_err);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL timeout_stream i=%0d got %h exp %h", i, obs, expv);
            end
        end
        checks++;
        if (nv !== 2 || ne !== 2 || bus.cmd !== 8'h01 || bus.cmd_data !== 16'h0010) begin
            errors++;
            $display("FAIL timeout_summary got valid=%0d err=%0d cmd=%h data=%h exp 2 2 01 0010",
                     nv, ne, bus.cmd, bus.cmd_data);
        end
    endtask

    task automatic test_back_to_back();
        int nv = 0;
        int ngood = 0;
        bit good;
        stimq.delete();
        for (int f = 0; f < 8; f++) begin
            good = CSUM_ON ? bit'($urandom_range(0, 3) != 0) : 1'b1;
            ngood += int'(good);
            add_frame(8'($urandom), 16'($urandom), good, 0);
        end
        foreach (stimq[i]) begin
            drive(stimq[i]);
            nv += int'(bus.cmd_valid);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL back_to_back i=%0d got %h exp %h", i, obs, expv);
            end
        end
        checks++;
        if (nv !== ngood) begin
            errors++;
            $display("FAIL back_to_back_count got %0d exp %0d", nv, ngood);
        end
    endtask

    task automatic test_random();
        int kind;
        stimq.delete();
        for (int n = 0; n < 250; n++) begin
            kind = $urandom_range(0, 9);
            if (kind < 2) begin
                add_byte(8'($urandom));
            end else if (kind < 6) begin
                add_frame(8'($urandom), 16'($urandom), 1'b1, 3);
            end else if (kind < 7) begin
                add_frame(8'($urandom), 16'($urandom), 1'b0, 3);
            end else if (kind < 8) begin
                add_byte(HDR);
                for (int k = 0; k < $urandom_range(0, FLEN - 2); k++) add_byte(8'($urandom));
                add_idle(TO + $urandom_range(0, 3));
            end else if (kind < 9) begin
                add_idle($urandom_range(TO - 2, TO + 1));
            end else begin
                add_idle($urandom_range(0, 4));
            end
        end
        foreach (stimq[i]) begin
            drive(stimq[i]);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL random_stream i=%0d got %h exp %h", i, obs, expv);
            end
            checks++;
            if (bus.cmd_valid && bus.frame_err) begin
                errors++;
                $display("FAIL pulse_exclusive i=%0d got both high exp at most one", i);
            end
        end
    endtask

    task automatic test_reset_midframe();
        int np = 0;
        logic [7:0] c;
        stimq.delete();
        add_byte(HDR); add_byte(8'h01); add_byte(8'h12);
        foreach (stimq[i]) begin
            drive(stimq[i]);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL midreset_pre i=%0d got %h exp %h", i, obs, expv);
            end
        end
        bus.rx_valid = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (obs !== 27'd0) begin
            errors++;
            $display("FAIL midreset_async got %h exp %h", obs, 27'd0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        stimq.delete();
        add_idle(5);
        add_frame(8'h07, 16'hBEEF, 1'b1, 0);
        foreach (stimq[i]) begin
            drive(stimq[i]);
            np += int'(bus.cmd_valid) + int'(bus.frame_err);
            checks++;
            if (obs !== expv) begin
                errors++;
                $display("FAIL midreset_post i=%0d got %h exp %h", i, obs, expv);
            end
        end
        c = bus.cmd;
        checks++;
        if (np !== 1 || c !== 8'h07 || bus.cmd_data !== 16'hBEEF) begin
            errors++;
            $display("FAIL midreset_result got pulses=%0d cmd=%h data=%h exp 1 07 BEEF",
                     np, c, bus.cmd_data);
        end
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        model_reset();
        test_reset();
        test_directed();
        test_timeout();
        test_back_to_back();
        test_random();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
